// File: rtl/mips_pkg.sv
// mips_pkg: shared levels, widths, opcode/funct constants and the ALU for mips_sopc.
package mips_pkg;
  localparam logic EN = 1'b1;
  localparam logic DIS = 1'b0;
  localparam int WORD_W = 32;
  localparam int REG_AW = 5;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_AW-1:0] reg_t;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_JR = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;
  typedef enum logic [3:0] {
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;
  function automatic word_t alu(input alu_op_t op, input word_t a, input word_t b, input logic [4:0] sh);
    case (op)
      ALU_AND: return a & b;
      ALU_OR: return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOR: return ~(a | b);
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_SLL: return b << sh;
      ALU_SRL: return b >> sh;
      ALU_SRA: return word_t'($signed(b) >>> sh);
      ALU_LUI: return {b[15:0], 16'h0000};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async read ports, one write port, $0 hard-wired to zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  reg_t  i_ra1,
  input  reg_t  i_ra2,
  input  logic  i_we,
  input  reg_t  i_wa,
  input  word_t i_wd,
  output word_t o_rd1,
  output word_t o_rd2
);
  word_t r_regs [32];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    else if (i_we && i_wa != '0) r_regs[i_wa] <= i_wd;
  end
  assign o_rd1 = i_ra1 == '0 ? '0 : r_regs[i_ra1];
  assign o_rd2 = i_ra2 == '0 ? '0 : r_regs[i_ra2];
endmodule

// File: rtl/mips_sopc.sv
// mips_sopc: single-cycle MIPS integer core with a parameter-initialised instruction ROM.
// Debug outputs expose the commit pending at the end of the current cycle.
module mips_sopc
  import mips_pkg::*;
#(
  parameter int ROM_AW = 6,
  parameter word_t ROM_INIT [2**ROM_AW] = '{default: '0}
) (
  input  logic  clk,
  input  logic  rst,
  output word_t pc_o,
  output logic  wb_we_o,
  output reg_t  wb_addr_o,
  output word_t wb_data_o
);
  word_t r_pc;
  word_t w_inst, w_pc4, w_rs_data, w_rt_data, w_b, w_next, w_sext, w_zext, w_br, w_jt, w_wd;
  logic [5:0] w_op, w_funct;
  reg_t w_rs, w_rt, w_rd, w_dst;
  logic [4:0] w_shamt;
  logic w_we, w_link;
  alu_op_t w_alu_op;
  assign w_inst = ROM_INIT[r_pc[ROM_AW+1:2]];
  assign w_op = w_inst[31:26];
  assign w_rs = w_inst[25:21];
  assign w_rt = w_inst[20:16];
  assign w_rd = w_inst[15:11];
  assign w_shamt = w_inst[10:6];
  assign w_funct = w_inst[5:0];
  assign w_pc4 = r_pc + 32'd4;
  assign w_sext = {{16{w_inst[15]}}, w_inst[15:0]};
  assign w_zext = {16'h0000, w_inst[15:0]};
  assign w_br = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_jt = {w_pc4[31:28], w_inst[25:0], 2'b00};
  always_comb begin
    w_alu_op = ALU_OR;
    w_b = w_rt_data;
    w_we = DIS;
    w_dst = w_rt;
    w_next = w_pc4;
    w_link = DIS;
    case (w_op)
      OP_SPECIAL: begin
        w_dst = w_rd;
        w_we = EN;
        case (w_funct)
          F_AND: w_alu_op = ALU_AND;
          F_OR: w_alu_op = ALU_OR;
          F_XOR: w_alu_op = ALU_XOR;
          F_NOR: w_alu_op = ALU_NOR;
          F_ADDU: w_alu_op = ALU_ADD;
          F_SUBU: w_alu_op = ALU_SUB;
          F_SLT: w_alu_op = ALU_SLT;
          F_SLTU: w_alu_op = ALU_SLTU;
          F_SLL: w_alu_op = ALU_SLL;
          F_SRL: w_alu_op = ALU_SRL;
          F_SRA: w_alu_op = ALU_SRA;
          F_JR: begin
            w_we = DIS;
            w_next = w_rs_data;
          end
          default: w_we = DIS;
        endcase
      end
      OP_ADDIU: begin w_alu_op = ALU_ADD; w_b = w_sext; w_we = EN; end
      OP_SLTI: begin w_alu_op = ALU_SLT; w_b = w_sext; w_we = EN; end
      OP_ANDI: begin w_alu_op = ALU_AND; w_b = w_zext; w_we = EN; end
      OP_ORI: begin w_alu_op = ALU_OR; w_b = w_zext; w_we = EN; end
      OP_XORI: begin w_alu_op = ALU_XOR; w_b = w_zext; w_we = EN; end
      OP_LUI: begin w_alu_op = ALU_LUI; w_b = w_zext; w_we = EN; end
      OP_BEQ: w_next = w_rs_data == w_rt_data ? w_br : w_pc4;
      OP_BNE: w_next = w_rs_data != w_rt_data ? w_br : w_pc4;
      OP_J: w_next = w_jt;
      OP_JAL: begin
        w_next = w_jt;
        w_we = EN;
        w_dst = 5'd31;
        w_link = EN;
      end
      default: ;
    endcase
  end
  assign w_wd = w_link ? w_pc4 : alu(w_alu_op, w_rs_data, w_b, w_shamt);
  always_ff @(posedge clk) r_pc <= rst ? '0 : w_next;
  mips_regfile u_rf (
    .clk(clk), .rst(rst),
    .i_ra1(w_rs), .i_ra2(w_rt),
    .i_we(w_we), .i_wa(w_dst), .i_wd(w_wd),
    .o_rd1(w_rs_data), .o_rd2(w_rt_data)
  );
  // Reset dominates the trace so nothing appears to commit while rst is high.
  assign pc_o = rst ? '0 : r_pc;
  assign wb_we_o = !rst && w_we && w_dst != '0;
  assign wb_addr_o = rst ? '0 : w_dst;
  assign wb_data_o = rst ? '0 : w_wd;
endmodule

// File: tb/tb_mips_sopc.sv
// tb_mips_sopc: directed commit-trace checks of mips_sopc against hand-decoded programs.
module tb_mips_sopc;
  import mips_pkg::*;
  typedef struct {
    word_t pc;
    logic  we;
    reg_t  addr;
    word_t data;
  } vec_t;
  localparam word_t IMG_A [64] = '{
    0: 32'h34011100, 1: 32'h34220020, 2: 32'h3C03ABCD, 3: 32'h00432025,
    4: 32'h2405FFFF, 5: 32'h00A53021, 6: 32'h00A0382A, 7: 32'h00A0402B,
    8: 32'h00054903, 9: 32'h34010003, 10: 32'h2421FFFF, 11: 32'h1420FFFE,
    12: 32'h00825023, 13: 32'h00005827, 14: 32'h00036100, 15: 32'h00036F02,
    16: 32'h00837026, 17: 32'h30AF8001, 18: 32'h3810FFFF, 19: 32'h28B10000,
    20: 32'hFC000000, 21: 32'h34000005, 22: 32'h08000019, 23: 32'h34120BAD,
    24: 32'h00000000, 25: 32'h34130070, 26: 32'h02600008, 27: 32'h34140BAD,
    28: 32'h1000FFFF, default: 32'h0
  };
  localparam word_t IMG_B [64] = '{
    0: 32'h0C000008, 8: 32'h34000005, 9: 32'h1000FFFF, default: 32'h0
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  word_t a_pc, a_data, b_pc, b_data;
  logic a_we, b_we;
  reg_t a_addr, b_addr;
  int checks = 0;
  int errors = 0;
  vec_t tv [32];
  vec_t jv [4];
  mips_sopc #(.ROM_AW(6), .ROM_INIT(IMG_A)) u_a (
    .clk(clk), .rst(rst), .pc_o(a_pc), .wb_we_o(a_we), .wb_addr_o(a_addr), .wb_data_o(a_data)
  );
  mips_sopc #(.ROM_AW(6), .ROM_INIT(IMG_B)) u_b (
    .clk(clk), .rst(rst), .pc_o(b_pc), .wb_we_o(b_we), .wb_addr_o(b_addr), .wb_data_o(b_data)
  );
  always #10 clk = ~clk;
  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input int n, input logic with_b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("a_pc[%0d]", i), a_pc, tv[i].pc);
      chk($sformatf("a_we[%0d]", i), word_t'(a_we), word_t'(tv[i].we));
      if (tv[i].we) begin
        chk($sformatf("a_addr[%0d]", i), word_t'(a_addr), word_t'(tv[i].addr));
        chk($sformatf("a_data[%0d]", i), a_data, tv[i].data);
      end
      if (with_b && i < 4) begin
        chk($sformatf("b_pc[%0d]", i), b_pc, jv[i].pc);
        chk($sformatf("b_we[%0d]", i), word_t'(b_we), word_t'(jv[i].we));
        if (jv[i].we) begin
          chk($sformatf("b_addr[%0d]", i), word_t'(b_addr), word_t'(jv[i].addr));
          chk($sformatf("b_data[%0d]", i), b_data, jv[i].data);
        end
      end
    end
  endtask
  initial begin
    word_t acc;
    tv[0] = '{32'h00, 1, 1, 32'h00001100};
    tv[1] = '{32'h04, 1, 2, 32'h00001120};
    tv[2] = '{32'h08, 1, 3, 32'hABCD0000};
    tv[3] = '{32'h0C, 1, 4, 32'hABCD1120};
    tv[4] = '{32'h10, 1, 5, 32'hFFFFFFFF};
    tv[5] = '{32'h14, 1, 6, 32'hFFFFFFFE};
    tv[6] = '{32'h18, 1, 7, 32'h00000001};
    tv[7] = '{32'h1C, 1, 8, 32'h00000000};
    tv[8] = '{32'h20, 1, 9, 32'hFFFFFFFF};
    tv[9] = '{32'h24, 1, 1, 32'h00000003};
    tv[10] = '{32'h28, 1, 1, 32'h00000002};
    tv[11] = '{32'h2C, 0, 0, 32'h0};
    tv[12] = '{32'h28, 1, 1, 32'h00000001};
    tv[13] = '{32'h2C, 0, 0, 32'h0};
    tv[14] = '{32'h28, 1, 1, 32'h00000000};
    tv[15] = '{32'h2C, 0, 0, 32'h0};
    tv[16] = '{32'h30, 1, 10, 32'hABCD0000};
    tv[17] = '{32'h34, 1, 11, 32'hFFFFFFFF};
    tv[18] = '{32'h38, 1, 12, 32'hBCD00000};
    tv[19] = '{32'h3C, 1, 13, 32'h0000000A};
    tv[20] = '{32'h40, 1, 14, 32'h00001120};
    tv[21] = '{32'h44, 1, 15, 32'h00008001};
    tv[22] = '{32'h48, 1, 16, 32'h0000FFFF};
    tv[23] = '{32'h4C, 1, 17, 32'h00000001};
    tv[24] = '{32'h50, 0, 0, 32'h0};
    tv[25] = '{32'h54, 0, 0, 32'h0};
    tv[26] = '{32'h58, 0, 0, 32'h0};
    tv[27] = '{32'h64, 1, 19, 32'h00000070};
    tv[28] = '{32'h68, 0, 0, 32'h0};
    tv[29] = '{32'h70, 0, 0, 32'h0};
    tv[30] = '{32'h70, 0, 0, 32'h0};
    tv[31] = '{32'h70, 0, 0, 32'h0};
    jv[0] = '{32'h00, 1, 31, 32'h00000004};
    jv[1] = '{32'h20, 0, 0, 32'h0};
    jv[2] = '{32'h24, 0, 0, 32'h0};
    jv[3] = '{32'h24, 0, 0, 32'h0};
    #100;
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_we", word_t'(a_we), 32'h0);
    chk("rst_addr", word_t'(a_addr), 32'h0);
    chk("rst_data", a_data, 32'h0);
    #95 rst = 1'b0;
    run(32, 1'b1);
    chk("b_r0", u_b.u_rf.r_regs[0], 32'h0);
    chk("b_r31", u_b.u_rf.r_regs[31], 32'h00000004);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    run(13, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", a_pc, 32'h0);
    chk("mid_rst_we", word_t'(a_we), 32'h0);
    @(posedge clk) #1 rst = 1'b0;
    acc = '0;
    for (int r = 0; r < 32; r++) acc = acc | u_a.u_rf.r_regs[r];
    chk("regs_zero", acc, 32'h0);
    run(6, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
